sr_cmd_gen: RTL and testbench



---
 rtl/sr_cmd_gen_pkg.sv | 22 ++
 rtl/sr_cmd_gen_debounce.sv | 53 +++++
 rtl/sr_cmd_gen.sv | 119 +++++++++++
 tb/tb_sr_cmd_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sr_cmd_gen_pkg.sv
// Shared types and width helpers for the s/r command generator.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLDOFF
  } state_t;

  localparam int unsigned CMD_CNT_W = 8;

  // Debounce counter width: must hold 0..DEBOUNCE_CYCLES-1.
  function automatic int unsigned cnt_w(input int unsigned d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction

  // Holdoff counter width: must hold 0..HOLDOFF_CYCLES-1, at least one bit.
  function automatic int unsigned hold_w(input int unsigned h);
    return (h < 2) ? 1 : $clog2(h);
  endfunction

endpackage

// File: rtl/sr_cmd_gen_debounce.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge detect
// for one raw request line.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic rise_o
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next debounced level: toggle on the edge the count would reach the limit.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Rise is taken from the next-state level so the pending flag is set on
  // the same edge the debounced level goes high.
  assign rise_o = db_d & ~db_q;

  // Synchronizer, debounce counter and debounced level registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns raw set/reset request lines into clean, arbitrated, rate-limited
// single-cycle s/r command pulses for the downstream SR flip-flop.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 2,
  parameter bit          RESET_WINS      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_in,
  input  logic                 rst_in,
  output logic                 s,
  output logic                 r,
  output logic                 busy,
  output logic                 conflict,
  output logic [CMD_CNT_W-1:0] cmd_cnt
);

  localparam int unsigned HW = hold_w(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  logic rise_s, rise_r;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk    (clk),
    .reset  (reset),
    .din_i  (set_in),
    .rise_o (rise_s)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk    (clk),
    .reset  (reset),
    .din_i  (rst_in),
    .rise_o (rise_r)
  );

  state_t                 state_q;
  logic [HW-1:0]          hold_q;
  logic                   pend_s_q, pend_r_q;
  logic                   s_q, r_q, busy_q, conflict_q;
  logic [CMD_CNT_W-1:0]   cnt_q;

  // Pending capture, arbitration FSM and registered command outputs.
  // Pending flags are consumed on the edge entering ISSUE; a rise arriving on
  // that same edge is kept as a fresh request rather than merged away.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      pend_s_q   <= pend_s_q | rise_s;
      pend_r_q   <= pend_r_q | rise_r;
      case (state_q)
        IDLE: begin
          if (pend_s_q || pend_r_q) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
            cnt_q   <= cnt_q + CMD_CNT_W'(1);
            if (pend_s_q && pend_r_q) begin
              conflict_q <= 1'b1;
              pend_s_q   <= rise_s;
              pend_r_q   <= rise_r;
              if (RESET_WINS) r_q <= 1'b1;
              else            s_q <= 1'b1;
            end else if (pend_r_q) begin
              r_q      <= 1'b1;
              pend_r_q <= rise_r;
            end else begin
              s_q      <= 1'b1;
              pend_s_q <= rise_s;
            end
          end
        end
        ISSUE: begin
          hold_q <= '0;
          if (HOLDOFF_CYCLES > 0) begin
            state_q <= HOLDOFF;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        HOLDOFF: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;
  assign cmd_cnt  = cnt_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen: two instances share stimulus, one with
// reset priority and one with set priority (DEBOUNCE=4, HOLDOFF=2).
module tb_sr_cmd_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       set_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       s0, r0, busy0, conf0;
  logic       s1, r1, busy1, conf1;
  logic [7:0] cnt0, cnt1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned s0_n = 0, r0_n = 0, s1_n = 0, r1_n = 0;

  always #5 clk = ~clk;

  sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(2), .RESET_WINS(1'b1)) dut0 (
    .clk(clk), .reset(reset), .set_in(set_in), .rst_in(rst_in),
    .s(s0), .r(r0), .busy(busy0), .conflict(conf0), .cmd_cnt(cnt0)
  );

  sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(2), .RESET_WINS(1'b0)) dut1 (
    .clk(clk), .reset(reset), .set_in(set_in), .rst_in(rst_in),
    .s(s1), .r(r1), .busy(busy1), .conflict(conf1), .cmd_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Pulse tallies and the s/r exclusivity invariant, sampled mid-cycle.
  always @(negedge clk) begin
    if (s0) s0_n++;
    if (r0) r0_n++;
    if (s1) s1_n++;
    if (r1) r1_n++;
    chk("s_and_r_0", {31'b0, s0 & r0}, 32'd0);
    chk("s_and_r_1", {31'b0, s1 & r1}, 32'd0);
  end

  initial begin
    // Reset held with toggling inputs.
    for (int i = 0; i < 5; i++) begin
      set_in = i[0];
      rst_in = ~i[0];
      tick();
      chk("rst_s",    {31'b0, s0},    32'd0);
      chk("rst_r",    {31'b0, r0},    32'd0);
      chk("rst_busy", {31'b0, busy0}, 32'd0);
      chk("rst_conf", {31'b0, conf0}, 32'd0);
      chk("rst_cnt",  {24'b0, cnt0},  32'd0);
    end
    reset  = 1'b0;
    set_in = 1'b0;
    rst_in = 1'b0;
    wait_cycles(10);
    chk("post_rst_cnt", {24'b0, cnt0}, 32'd0);
    chk("post_rst_pulses", s0_n + r0_n, 32'd0);

    // Clean set: s only in the cycle after edge 7, busy for 3 cycles.
    set_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("clean_s",    {31'b0, s0},    {31'b0, e == 7});
      chk("clean_s1",   {31'b0, s1},    {31'b0, e == 7});
      chk("clean_r",    {31'b0, r0},    32'd0);
      chk("clean_conf", {31'b0, conf0}, 32'd0);
      chk("clean_busy", {31'b0, busy0}, {31'b0, (e >= 7) && (e <= 9)});
      chk("clean_cnt",  {24'b0, cnt0},  (e >= 7) ? 32'd1 : 32'd0);
    end
    set_in = 1'b0;
    wait_cycles(12);
    chk("clean_tot_s", s0_n, 32'd1);
    chk("clean_tot_r", r0_n, 32'd0);

    // Glitch of 3 samples is rejected.
    rst_in = 1'b1;
    wait_cycles(3);
    rst_in = 1'b0;
    wait_cycles(12);
    chk("glitch_r",   r0_n, 32'd0);
    chk("glitch_cnt", {24'b0, cnt0}, 32'd1);

    // Exactly 4 samples is accepted.
    rst_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 4) rst_in = 1'b0;
      chk("db4_r", {31'b0, r0}, {31'b0, e == 7});
    end
    wait_cycles(10);
    chk("db4_tot_r", r0_n, 32'd1);
    chk("db4_tot_s", s0_n, 32'd1);
    chk("db4_cnt",   {24'b0, cnt0}, 32'd2);

    // Simultaneous requests: priority and conflict.
    set_in = 1'b1;
    rst_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("sim_r0",    {31'b0, r0},    {31'b0, e == 7});
      chk("sim_s0",    {31'b0, s0},    32'd0);
      chk("sim_conf0", {31'b0, conf0}, {31'b0, e == 7});
      chk("sim_s1",    {31'b0, s1},    {31'b0, e == 7});
      chk("sim_r1",    {31'b0, r1},    32'd0);
      chk("sim_conf1", {31'b0, conf1}, {31'b0, e == 7});
    end
    set_in = 1'b0;
    rst_in = 1'b0;
    wait_cycles(15);
    chk("sim_tot_s0", s0_n, 32'd1);
    chk("sim_tot_r0", r0_n, 32'd2);
    chk("sim_tot_s1", s1_n, 32'd2);
    chk("sim_tot_r1", r1_n, 32'd1);
    chk("sim_cnt0", {24'b0, cnt0}, 32'd3);
    chk("sim_cnt1", {24'b0, cnt1}, 32'd3);

    // Reset request arriving during holdoff is served one idle cycle later.
    set_in = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 2) rst_in = 1'b1;
      chk("hold_s",    {31'b0, s0},    {31'b0, e == 7});
      chk("hold_r",    {31'b0, r0},    {31'b0, e == 11});
      chk("hold_conf", {31'b0, conf0}, 32'd0);
      chk("hold_busy", {31'b0, busy0},
          {31'b0, ((e >= 7) && (e <= 9)) || ((e >= 11) && (e <= 13))});
    end
    set_in = 1'b0;
    rst_in = 1'b0;
    wait_cycles(15);
    chk("hold_cnt", {24'b0, cnt0}, 32'd5);
    chk("hold_tot_r", r0_n, 32'd3);

    // Reset during ISSUE drops s and discards a freshly pending reset request.
    set_in = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 1) rst_in = 1'b1;
    end
    chk("mid_s_issue", {31'b0, s0}, 32'd1);
    chk("mid_cnt_issue", {24'b0, cnt0}, 32'd6);
    reset  = 1'b1;
    set_in = 1'b0;
    rst_in = 1'b0;
    tick();
    chk("mid_s_after",    {31'b0, s0},    32'd0);
    chk("mid_busy_after", {31'b0, busy0}, 32'd0);
    chk("mid_cnt_after",  {24'b0, cnt0},  32'd0);
    reset = 1'b0;
    wait_cycles(20);
    chk("mid_no_r",  r0_n, 32'd3);
    chk("mid_cnt_0", {24'b0, cnt0}, 32'd0);

    // Command counter wraps 255 -> 0.
    for (int i = 0; i < 255; i++) begin
      set_in = 1'b1;
      wait_cycles(5);
      set_in = 1'b0;
      wait_cycles(5);
    end
    wait_cycles(15);
    chk("wrap_255", {24'b0, cnt0}, 32'd255);
    set_in = 1'b1;
    wait_cycles(5);
    set_in = 1'b0;
    wait_cycles(15);
    chk("wrap_0", {24'b0, cnt0}, 32'd0);
    chk("wrap_0_dut1", {24'b0, cnt1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
